// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
//   - opcode values recognised by the sequencer
//   - 4-bit state encodings (also exported on the debug state port)
//   - PC source and ALU B-operand select encodings
//   - ALU operation used for PC increment / branch target add
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Address arithmetic reuses the ADDIU encoding as a plain add.
  localparam logic [5:0] ALUOP_ADD = OP_ADDIU;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_IMMEX  = 4'd8,
    ST_IMMWB  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUSRCB_REGB  = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM   = 2'd2;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'd3;

  function automatic logic isImmOp(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI)  || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts cycles a memory request has been left waiting.
// Ports:
//   i_clk, i_rst  clock / async active-high reset (count -> 0)
//   i_clear       synchronous clear (takes priority over counting)
//   i_countEn     advance the count by one this cycle
//   o_expire      count has reached MEM_WAIT_MAX-1
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_countEn,
  output logic o_expire
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [WAIT_W-1:0] waitCnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      waitCnt <= '0;
    end else if (i_clear) begin
      waitCnt <= '0;
    end else if (i_countEn && (waitCnt != LIMIT)) begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  assign o_expire = (waitCnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer. Walks the shared datapath through
// fetch/decode/execute/memory/writeback, owns the unified memory port with a
// ready handshake plus timeout, and counts retired instructions.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_instrCode         opcode field from the instruction register
//   i_zero              ALU zero flag
//   i_memReady          memory completes the current request this cycle
//   o_memReq/o_memWe    memory request valid / is a write
//   o_iOrD              address source (0=PC, 1=ALUOut)
//   o_irWrite/o_pcWrite IR and PC load strobes
//   o_pcSrc, o_aluSrcA, o_aluSrcB, o_aluOp, o_extOp  datapath selects
//   o_regWrite, o_regDst, o_memToReg                 register writeback
//   o_memErr, o_illegal one-cycle error pulses
//   o_retired           retired-instruction count (wraps)
//   o_state             current state (debug)
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on ready
// DECODE | latch opcode, precompute branch target into ALUOut
// MEMADR | compute load/store address
// MEMRD  | data read, wait for ready
// MEMWB  | write loaded data to rt
// MEMWR  | data write, wait for ready
// EXEC   | R-type ALU operation
// ALUWB  | write R-type result to rd
// IMMEX  | immediate ALU operation
// IMMWB  | write immediate result to rt
// BRANCH | compare and conditionally load branch target
// JUMP   | load jump target
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_instrCode,
  input  logic             i_zero,
  input  logic             i_memReady,
  output logic             o_memReq,
  output logic             o_memWe,
  output logic             o_iOrD,
  output logic             o_irWrite,
  output logic             o_pcWrite,
  output logic [1:0]       o_pcSrc,
  output logic             o_aluSrcA,
  output logic [1:0]       o_aluSrcB,
  output logic [5:0]       o_aluOp,
  output logic             o_extOp,
  output logic             o_regWrite,
  output logic             o_regDst,
  output logic             o_memToReg,
  output logic             o_memErr,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired,
  output logic [3:0]       o_state
);

  state_t           state, stateNext;
  logic [5:0]       opQ;
  logic [CNT_W-1:0] retiredQ;
  logic             retire;
  logic             isMemState;
  logic             waitExpire;
  logic             timeout;
  logic             waitClear;
  logic             immSigned;

  assign isMemState = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
  // Ready arriving on the limit cycle wins over the timeout.
  assign timeout    = isMemState && waitExpire && !i_memReady;
  // Restart the count whenever a memory state is (re)entered, including FETCH->FETCH after a timeout.
  assign waitClear  = !isMemState || (stateNext != state) || timeout;
  assign immSigned  = (opQ == OP_ADDI) || (opQ == OP_ADDIU);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_waitTimer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (waitClear),
    .i_countEn (isMemState && !i_memReady),
    .o_expire  (waitExpire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_FETCH;
      opQ      <= '0;
      retiredQ <= '0;
    end else begin
      state <= stateNext;
      if (state == ST_DECODE) opQ <= i_instrCode;
      if (retire) retiredQ <= retiredQ + CNT_W'(1);
    end
  end

  always_comb begin
    stateNext  = state;
    retire     = 1'b0;
    o_memReq   = 1'b0;
    o_memWe    = 1'b0;
    o_iOrD     = 1'b0;
    o_irWrite  = 1'b0;
    o_pcWrite  = 1'b0;
    o_pcSrc    = PCSRC_ALU;
    o_aluSrcA  = 1'b0;
    o_aluSrcB  = ALUSRCB_REGB;
    o_aluOp    = 6'h00;
    o_extOp    = 1'b0;
    o_regWrite = 1'b0;
    o_regDst   = 1'b0;
    o_memToReg = 1'b0;
    o_memErr   = 1'b0;
    o_illegal  = 1'b0;

    // Reset forces every strobe and select low even though state already reads FETCH.
    if (!i_rst) begin
      case (state)
        ST_FETCH: begin
          o_memReq  = 1'b1;
          o_aluSrcB = ALUSRCB_FOUR;
          o_aluOp   = ALUOP_ADD;
          if (timeout) begin
            o_memErr  = 1'b1;
          end else if (i_memReady) begin
            o_irWrite = 1'b1;
            o_pcWrite = 1'b1;
            stateNext = ST_DECODE;
          end
        end
        ST_DECODE: begin
          o_aluSrcB = ALUSRCB_IMMSH;
          o_extOp   = 1'b1;
          o_aluOp   = ALUOP_ADD;
          if (i_instrCode == OP_LW || i_instrCode == OP_SW) stateNext = ST_MEMADR;
          else if (i_instrCode == OP_RTYPE)                 stateNext = ST_EXEC;
          else if (isImmOp(i_instrCode))                    stateNext = ST_IMMEX;
          else if (i_instrCode == OP_BEQ || i_instrCode == OP_BNE) stateNext = ST_BRANCH;
          else if (i_instrCode == OP_J)                     stateNext = ST_JUMP;
          else begin
            o_illegal = 1'b1;
            stateNext = ST_FETCH;
          end
        end
        ST_MEMADR: begin
          o_aluSrcA = 1'b1;
          o_aluSrcB = ALUSRCB_IMM;
          o_extOp   = 1'b1;
          o_aluOp   = opQ;
          stateNext = (opQ == OP_LW) ? ST_MEMRD : ST_MEMWR;
        end
        ST_MEMRD: begin
          o_memReq = 1'b1;
          o_iOrD   = 1'b1;
          if (timeout) begin
            o_memErr  = 1'b1;
            stateNext = ST_FETCH;
          end else if (i_memReady) begin
            stateNext = ST_MEMWB;
          end
        end
        ST_MEMWB: begin
          o_regWrite = 1'b1;
          o_memToReg = 1'b1;
          retire     = 1'b1;
          stateNext  = ST_FETCH;
        end
        ST_MEMWR: begin
          o_memReq = 1'b1;
          o_memWe  = 1'b1;
          o_iOrD   = 1'b1;
          if (timeout) begin
            o_memErr  = 1'b1;
            stateNext = ST_FETCH;
          end else if (i_memReady) begin
            retire    = 1'b1;
            stateNext = ST_FETCH;
          end
        end
        ST_EXEC: begin
          o_aluSrcA = 1'b1;
          stateNext = ST_ALUWB;
        end
        ST_ALUWB: begin
          o_regWrite = 1'b1;
          o_regDst   = 1'b1;
          retire     = 1'b1;
          stateNext  = ST_FETCH;
        end
        ST_IMMEX: begin
          o_aluSrcA = 1'b1;
          o_aluSrcB = ALUSRCB_IMM;
          o_aluOp   = opQ;
          o_extOp   = immSigned;
          stateNext = ST_IMMWB;
        end
        ST_IMMWB: begin
          o_regWrite = 1'b1;
          o_extOp    = immSigned;
          retire     = 1'b1;
          stateNext  = ST_FETCH;
        end
        ST_BRANCH: begin
          o_aluSrcA = 1'b1;
          o_aluOp   = opQ;
          o_pcSrc   = PCSRC_ALUOUT;
          o_pcWrite = ((opQ == OP_BEQ) && i_zero) || ((opQ == OP_BNE) && !i_zero);
          retire    = 1'b1;
          stateNext = ST_FETCH;
        end
        ST_JUMP: begin
          o_pcSrc   = PCSRC_JUMP;
          o_pcWrite = 1'b1;
          retire    = 1'b1;
          stateNext = ST_FETCH;
        end
        default: stateNext = ST_FETCH;
      endcase
    end
  end

  assign o_retired = retiredQ;
  assign o_state   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] instrCode = 6'h00;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic       memReq, memWe, iOrD, irWrite, pcWrite, aluSrcA, extOp;
  logic       regWrite, regDst, memToReg, memErr, illegal;
  logic [1:0] pcSrc, aluSrcB;
  logic [5:0] aluOp;
  logic [3:0] retired;
  logic [3:0] state;

  int nAssert = 0;
  int nFail   = 0;

  multicycle_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_instrCode(instrCode), .i_zero(zero), .i_memReady(memReady),
    .o_memReq(memReq), .o_memWe(memWe), .o_iOrD(iOrD), .o_irWrite(irWrite), .o_pcWrite(pcWrite),
    .o_pcSrc(pcSrc), .o_aluSrcA(aluSrcA), .o_aluSrcB(aluSrcB), .o_aluOp(aluOp), .o_extOp(extOp),
    .o_regWrite(regWrite), .o_regDst(regDst), .o_memToReg(memToReg), .o_memErr(memErr),
    .o_illegal(illegal), .o_retired(retired), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; memReady = 1'b1; instrCode = 6'h00;
    repeat (2) @(posedge clk);
    #2;
    nAssert++; if (state !== 4'd0) begin nFail++; $display("FAIL reset_state: got %0d want 0", state); end
    nAssert++; if (memReq !== 1'b0) begin nFail++; $display("FAIL reset_memReq: got %0b want 0", memReq); end
    nAssert++; if (irWrite !== 1'b0) begin nFail++; $display("FAIL reset_irWrite: got %0b want 0", irWrite); end
    nAssert++; if (aluSrcB !== 2'd0) begin nFail++; $display("FAIL reset_aluSrcB: got %0d want 0", aluSrcB); end
    nAssert++; if (aluOp !== 6'h00) begin nFail++; $display("FAIL reset_aluOp: got %0h want 0", aluOp); end
    nAssert++; if (retired !== 4'd0) begin nFail++; $display("FAIL reset_retired: got %0d want 0", retired); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    instrCode = 6'h00; memReady = 1'b1; #1;
    nAssert++; if (state !== 4'd0) begin nFail++; $display("FAIL add_c1_state: got %0d want 0", state); end
    nAssert++; if ({memReq, iOrD, irWrite, pcWrite} !== 4'b1011) begin nFail++; $display("FAIL add_c1_strobes: got %b want 1011", {memReq, iOrD, irWrite, pcWrite}); end
    nAssert++; if ({aluSrcA, aluSrcB, aluOp} !== {1'b0, 2'd1, 6'h09}) begin nFail++; $display("FAIL add_c1_alu: got %b/%0d/%0h want 0/1/9", aluSrcA, aluSrcB, aluOp); end
    step();
    nAssert++; if (state !== 4'd1) begin nFail++; $display("FAIL add_c2_state: got %0d want 1", state); end
    nAssert++; if ({aluSrcB, extOp, aluOp} !== {2'd3, 1'b1, 6'h09}) begin nFail++; $display("FAIL add_c2_decode: got %0d/%b/%0h want 3/1/9", aluSrcB, extOp, aluOp); end
    step();
    nAssert++; if (state !== 4'd6) begin nFail++; $display("FAIL add_c3_state: got %0d want 6", state); end
    nAssert++; if ({aluSrcA, aluSrcB, aluOp} !== {1'b1, 2'd0, 6'h00}) begin nFail++; $display("FAIL add_c3_alu: got %b/%0d/%0h want 1/0/0", aluSrcA, aluSrcB, aluOp); end
    step();
    nAssert++; if (state !== 4'd7) begin nFail++; $display("FAIL add_c4_state: got %0d want 7", state); end
    nAssert++; if ({regWrite, regDst, memToReg} !== 3'b110) begin nFail++; $display("FAIL add_c4_wb: got %b want 110", {regWrite, regDst, memToReg}); end
    nAssert++; if (retired !== 4'd0) begin nFail++; $display("FAIL add_c4_retired: got %0d want 0", retired); end
    step();
    nAssert++; if (state !== 4'd0) begin nFail++; $display("FAIL add_done_state: got %0d want 0", state); end
    nAssert++; if (retired !== 4'd1) begin nFail++; $display("FAIL add_done_retired: got %0d want 1", retired); end
  endtask

  task automatic test_lw_wait();
    int reqCycles = 0;
    instrCode = 6'h23; memReady = 1'b1; #1;
    step();
    nAssert++; if (state !== 4'd1) begin nFail++; $display("FAIL lw_c2_state: got %0d want 1", state); end
    step();
    nAssert++; if (state !== 4'd2) begin nFail++; $display("FAIL lw_c3_state: got %0d want 2", state); end
    nAssert++; if ({aluSrcA, aluSrcB, extOp, aluOp} !== {1'b1, 2'd2, 1'b1, 6'h23}) begin nFail++; $display("FAIL lw_c3_alu: got %b/%0d/%b/%0h want 1/2/1/23", aluSrcA, aluSrcB, extOp, aluOp); end
    memReady = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      memReady = (c == 3); #1;
      if (state == 4'd3 && memReq && iOrD && !memWe) reqCycles++;
      nAssert++; if (memErr !== 1'b0) begin nFail++; $display("FAIL lw_memrd_memErr: cycle %0d got %b want 0", c, memErr); end
      step();
    end
    nAssert++; if (reqCycles !== 4) begin nFail++; $display("FAIL lw_memrd_reqCycles: got %0d want 4", reqCycles); end
    nAssert++; if (state !== 4'd4) begin nFail++; $display("FAIL lw_c8_state: got %0d want 4", state); end
    nAssert++; if ({regWrite, regDst, memToReg} !== 3'b101) begin nFail++; $display("FAIL lw_c8_wb: got %b want 101", {regWrite, regDst, memToReg}); end
    step();
    nAssert++; if (retired !== 4'd2) begin nFail++; $display("FAIL lw_done_retired: got %0d want 2", retired); end
  endtask

  task automatic test_branch();
    instrCode = 6'h04; zero = 1'b1; memReady = 1'b1; #1;
    step(); step();
    nAssert++; if (state !== 4'd10) begin nFail++; $display("FAIL beq_state: got %0d want 10", state); end
    nAssert++; if ({pcWrite, pcSrc} !== {1'b1, 2'd1}) begin nFail++; $display("FAIL beq_taken: got %b/%0d want 1/1", pcWrite, pcSrc); end
    nAssert++; if (aluOp !== 6'h04) begin nFail++; $display("FAIL beq_aluOp: got %0h want 4", aluOp); end
    step();
    nAssert++; if (retired !== 4'd3) begin nFail++; $display("FAIL beq_retired: got %0d want 3", retired); end
    instrCode = 6'h05; #1;
    step(); step();
    nAssert++; if ({pcWrite, pcSrc} !== {1'b0, 2'd1}) begin nFail++; $display("FAIL bne_zero1: got %b/%0d want 0/1", pcWrite, pcSrc); end
    zero = 1'b0; #1;
    nAssert++; if (pcWrite !== 1'b1) begin nFail++; $display("FAIL bne_zero0: got %b want 1", pcWrite); end
    step();
    nAssert++; if (retired !== 4'd4) begin nFail++; $display("FAIL bne_retired: got %0d want 4", retired); end
  endtask

  task automatic test_timeout();
    instrCode = 6'h00; memReady = 1'b0; #1;
    for (int c = 1; c <= 4; c++) begin
      nAssert++; if (memErr !== (c == 4)) begin nFail++; $display("FAIL timeout_memErr: cycle %0d got %b want %b", c, memErr, (c == 4)); end
      nAssert++; if ({irWrite, pcWrite, state} !== 6'b000000) begin nFail++; $display("FAIL timeout_noWrite: cycle %0d got %b/%b/%0d want 0/0/0", c, irWrite, pcWrite, state); end
      step();
    end
    nAssert++; if ({memErr, memReq, state} !== 6'b010000) begin nFail++; $display("FAIL timeout_refetch: got %b/%b/%0d want 0/1/0", memErr, memReq, state); end
    nAssert++; if (retired !== 4'd4) begin nFail++; $display("FAIL timeout_retired: got %0d want 4", retired); end
    memReady = 1'b1; #1;
  endtask

  task automatic test_illegal();
    instrCode = 6'h3F; memReady = 1'b1; #1;
    step();
    nAssert++; if ({state, illegal} !== {4'd1, 1'b1}) begin nFail++; $display("FAIL illegal_pulse: got %0d/%b want 1/1", state, illegal); end
    nAssert++; if ({regWrite, pcWrite} !== 2'b00) begin nFail++; $display("FAIL illegal_writes: got %b want 00", {regWrite, pcWrite}); end
    step();
    nAssert++; if ({state, illegal} !== {4'd0, 1'b0}) begin nFail++; $display("FAIL illegal_next: got %0d/%b want 0/0", state, illegal); end
    nAssert++; if (retired !== 4'd4) begin nFail++; $display("FAIL illegal_retired: got %0d want 4", retired); end
  endtask

  task automatic test_jump_wrap();
    instrCode = 6'h02; memReady = 1'b1; #1;
    for (int j = 0; j < 12; j++) begin
      step(); step();
      if (j == 0) begin
        nAssert++; if ({state, pcWrite, pcSrc} !== {4'd11, 1'b1, 2'd2}) begin nFail++; $display("FAIL jump_ctrl: got %0d/%b/%0d want 11/1/2", state, pcWrite, pcSrc); end
      end
      step();
      if (j == 10) begin
        nAssert++; if (retired !== 4'd15) begin nFail++; $display("FAIL wrap_pre: got %0d want 15", retired); end
      end
    end
    nAssert++; if (retired !== 4'd0) begin nFail++; $display("FAIL wrap_zero: got %0d want 0", retired); end
  endtask

  task automatic test_sw();
    instrCode = 6'h2B; memReady = 1'b1; #1;
    step(); step();
    nAssert++; if ({state, aluOp} !== {4'd2, 6'h2B}) begin nFail++; $display("FAIL sw_memadr: got %0d/%0h want 2/2b", state, aluOp); end
    step();
    nAssert++; if ({state, memReq, memWe, iOrD} !== {4'd5, 3'b111}) begin nFail++; $display("FAIL sw_memwr: got %0d/%b want 5/111", state, {memReq, memWe, iOrD}); end
    step();
    nAssert++; if ({state, retired} !== {4'd0, 4'd1}) begin nFail++; $display("FAIL sw_done: got %0d/%0d want 0/1", state, retired); end
  endtask

  task automatic test_reset_mid();
    instrCode = 6'h2B; memReady = 1'b1; #1;
    step(); step(); step();
    memReady = 1'b0; #1;
    nAssert++; if ({state, memWe} !== {4'd5, 1'b1}) begin nFail++; $display("FAIL rstmid_inwr: got %0d/%b want 5/1", state, memWe); end
    step();
    rst = 1'b1; #1;
    nAssert++; if ({memReq, memWe, iOrD, regWrite, pcWrite, irWrite} !== 6'b000000) begin nFail++; $display("FAIL rstmid_strobes: got %b want 000000", {memReq, memWe, iOrD, regWrite, pcWrite, irWrite}); end
    nAssert++; if ({state, retired} !== {4'd0, 4'd0}) begin nFail++; $display("FAIL rstmid_state: got %0d/%0d want 0/0", state, retired); end
    memReady = 1'b1;
    step();
    nAssert++; if ({memWe, retired} !== {1'b0, 4'd0}) begin nFail++; $display("FAIL rstmid_ready: got %b/%0d want 0/0", memWe, retired); end
    rst = 1'b0; #1;
    nAssert++; if ({state, memReq, memWe} !== {4'd0, 1'b1, 1'b0}) begin nFail++; $display("FAIL rstmid_release: got %0d/%b/%b want 0/1/0", state, memReq, memWe); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_timeout();
    test_illegal();
    test_jump_wrap();
    test_sw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
